mdu: RTL and testbench
======================

# mdu

Multiply/divide unit for the five-stage MIPS pipeline, located in the E stage beside the ALU. It accepts MULT/MULTU/DIV/DIVU with a fixed multi-cycle latency and owns the HI/LO registers. It executes MTHI/MTLO in a single cycle and supplies HI/LO to MFHI/MFLO. Its `busy` output is the signal the hazard/stall unit consumes, together with the E-stage start decode, to freeze the D stage for any multiply/divide-class instruction.

## Interface
- `MUL_LAT`, default 5: cycles `busy` stays high for MULT/MULTU.
- `DIV_LAT`, default 10: cycles `busy` stays high for DIV/DIVU.
- `clk`  in  1  pipeline clock; all state updates on the rising edge.
- `reset`  in  1  reset, asynchronous and active-low.
- `start`  in  1  E-stage instruction is MULT/MULTU/DIV/DIVU.
- `op`  in  3  operation: 0 NONE, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MTHI, 6 MTLO.
- `a`  in  32  rs operand (forwarded value).
- `b`  in  32  rt operand (forwarded value).
- `flush`  in  1  exception/interrupt taken this cycle; the E-stage instruction must have no effect.
- `busy`  out  1  operation in flight (registered).
- `hi`  out  32  HI register.
- `lo`  out  32  LO register.

## Operation
- State machine with two states:
  - IDLE → RUN when `start && !flush && op` ∈ {1..4}.
  - RUN → IDLE when the countdown reaches its last cycle.
- On IDLE→RUN:
  - Compute the full result from `a`/`b` in the same cycle and latch it into `hi_pend`/`lo_pend`.
  - Load the down-counter with `MUL_LAT` or `DIV_LAT`.
- MULT: signed 32×32→64. MULTU: unsigned 32×32→64. HI gets the upper 32 bits, LO the lower 32.
- DIV: signed; LO = quotient truncated toward zero, HI = remainder with the sign of the dividend. DIVU: unsigned.
- Signed overflow: 0x80000000 / 0xFFFFFFFF gives LO=0x80000000, HI=0.
- Divide by zero (`b`==0): the full `DIV_LAT` busy period still runs, and HI/LO are left unchanged at commit.
- Commit: `hi`/`lo` take the pending values on the edge ending the last RUN cycle.
- MTHI/MTLO, with `op`=5/6, `!flush`, state IDLE: write `a` into `hi`/`lo` on that edge. No `busy` is generated.
- `flush` high: `start`, MTHI and MTLO are all ignored that cycle. An operation already in RUN is not aborted (its instruction has already retired past M).
- `start` or MT* while in RUN is a protocol violation; the stall unit guarantees it never happens. The block ignores the request and asserts in simulation.
- `hi`/`lo` are stable throughout RUN and hold their pre-operation values until commit.

## Timing
- Reset (async assert, `reset`=0): `busy`=0, `hi`=0, `lo`=0, state IDLE, counter=0, pending registers=0. Deassertion is synchronous to `clk`.
- `start` sampled at the edge ending cycle T:
  - `busy`=1 for cycles T+1 … T+LAT.
  - `hi`/`lo` carry the new values from cycle T+LAT+1, when `busy`=0.
- Back-to-back: a new `start` is accepted in cycle T+LAT+1 at the earliest.
- MTHI/MTLO sampled at the edge ending cycle T: new value visible in cycle T+1 (zero-latency write, one-cycle read-after-write).
- `hi`/`lo`/`busy` are register outputs with no combinational path from the inputs.
- Reset asserted during RUN: the operation is discarded immediately and all outputs return to their reset values.

## Structure
- Shared package `mdu_pkg` holds:
  - the `op` encodings (MDU_NONE … MDU_MTLO);
  - default latencies MUL_LAT=5 and DIV_LAT=10.
  The decoder and the stall unit use the same encodings.
- Single module, no sub-modules. The arithmetic uses native `*` and `/`/`%` on sign-/zero-extended 64-bit operands.
- Counter width is $clog2(max(MUL_LAT, DIV_LAT)+1).

## Test plan
- MULT a=0xFFFFFFFE (−2), b=3 → `busy` high for exactly 5 cycles; then HI=0xFFFFFFFF, LO=0xFFFFFFFA. MULTU with the same operands → HI=0x00000002, LO=0xFFFFFFFA.
- DIV a=−7, b=2 → `busy` high for 10 cycles; then LO=0xFFFFFFFD, HI=0xFFFFFFFF. DIVU a=7, b=2 → LO=3, HI=1. DIV 0x80000000 / −1 → LO=0x80000000, HI=0.
- MTHI a=0x12345678, then DIV by 0 → `busy` high for 10 cycles; HI stays 0x12345678 and LO is unchanged.
- MULT with `flush`=1 in the start cycle → `busy` stays 0 and HI/LO are unchanged. MTLO with `flush`=1 → LO unchanged.
- MULT started, `flush` pulsed in cycle T+2 → `busy` still spans 5 cycles and the result commits.
- DIV in flight, `reset` pulled low in cycle T+4 → `busy`, `hi` and `lo` are 0 immediately. After release, a MULTU 5×5 gives LO=25 after 5 busy cycles.

Source files
------------

// File: rtl/mdu_pkg.sv
// -----------------------------------------------------------------------------
// mdu_pkg
//
// Shared definitions for the multiply/divide unit. The decoder, the hazard/stall
// unit and the MDU itself all use these operation encodings, so they must stay
// in one place.
//
// Contents:
//   mdu_op_e      3-bit operation encoding driven on the MDU 'op' input
//   MDU_MUL_LAT   default busy period for MULT/MULTU
//   MDU_DIV_LAT   default busy period for DIV/DIVU
//   mdu_result_t  HI/LO pair as produced by one multiply or divide
//   is_muldiv     op starts a multi-cycle operation
//   is_div_op     op is a divide (selects latency and divide-by-zero rule)
//   is_signed_op  op treats its operands as two's complement
// -----------------------------------------------------------------------------
package mdu_pkg;

  typedef enum logic [2:0] {
    MDU_NONE  = 3'd0,
    MDU_MULT  = 3'd1,
    MDU_MULTU = 3'd2,
    MDU_DIV   = 3'd3,
    MDU_DIVU  = 3'd4,
    MDU_MTHI  = 3'd5,
    MDU_MTLO  = 3'd6
  } mdu_op_e;

  localparam int MDU_MUL_LAT = 5;
  localparam int MDU_DIV_LAT = 10;

  typedef struct packed {
    logic [31:0] hi;
    logic [31:0] lo;
  } mdu_result_t;

  function automatic logic is_muldiv(input logic [2:0] code);
    return (code == MDU_MULT) || (code == MDU_MULTU) ||
           (code == MDU_DIV)  || (code == MDU_DIVU);
  endfunction

  function automatic logic is_div_op(input logic [2:0] code);
    return (code == MDU_DIV) || (code == MDU_DIVU);
  endfunction

  function automatic logic is_signed_op(input logic [2:0] code);
    return (code == MDU_MULT) || (code == MDU_DIV);
  endfunction

endpackage

// File: rtl/mdu.sv
// -----------------------------------------------------------------------------
// mdu
//
// Multiply/divide unit sitting beside the ALU in the E stage. Owns the HI/LO
// registers. MULT/MULTU/DIV/DIVU compute their full result in the accept cycle,
// park it in hi_pend/lo_pend, and hold 'busy' for a fixed number of cycles
// before committing to HI/LO. MTHI/MTLO write HI/LO directly in one cycle.
//
// Parameters:
//   MUL_LAT  cycles busy stays high for MULT/MULTU (>= 1)
//   DIV_LAT  cycles busy stays high for DIV/DIVU   (>= 1)
//
// Ports:
//   clk     in   pipeline clock, rising edge
//   reset   in   asynchronous, active-low reset
//   start   in   E-stage instruction is MULT/MULTU/DIV/DIVU
//   op      in   operation code (mdu_op_e)
//   a       in   rs operand (forwarded)
//   b       in   rt operand (forwarded)
//   flush   in   exception/interrupt this cycle; E-stage instruction squashed
//   busy    out  multiply/divide in flight (register output)
//   hi      out  HI register
//   lo      out  LO register
// -----------------------------------------------------------------------------
module mdu
  import mdu_pkg::*;
#(
  parameter int MUL_LAT = MDU_MUL_LAT,
  parameter int DIV_LAT = MDU_DIV_LAT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        flush,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam int MAX_LAT = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
  localparam int CNT_W   = $clog2(MAX_LAT + 1);

  localparam logic S_IDLE = 1'b0;
  localparam logic S_RUN  = 1'b1;

  logic              state;
  logic [CNT_W-1:0]  cnt;
  logic [31:0]       hi_pend;
  logic [31:0]       lo_pend;
  logic              pend_wr;

  logic              accept;
  logic              mt_ok;
  logic              last_cycle;
  logic              commit;

  logic              signed_op;
  logic [63:0]       a_ext;
  logic [63:0]       b_ext;
  logic [63:0]       b_div;
  logic [63:0]       prod;
  logic [31:0]       quo;
  logic [31:0]       rem;
  mdu_result_t       result;

  // Request qualification. A flushed instruction must leave no trace, and the
  // MT* writes are only honoured while idle so they can never race a commit.
  always_comb begin
    accept     = (state == S_IDLE) && start && !flush && is_muldiv(op);
    mt_ok      = (state == S_IDLE) && !flush;
    last_cycle = (state == S_RUN) && (cnt == CNT_W'(1));
    commit     = last_cycle && pend_wr;
  end

  // Arithmetic datapath. Operands are widened to 64 bits, sign- or
  // zero-extended by op, so one multiplier and one divider serve both the
  // signed and unsigned forms: the low 64 bits of a product are the same
  // either way, and a signed divide of zero-extended values is an unsigned
  // divide. Widening also makes 0x80000000 / -1 representable (quotient
  // +2^31 truncates to 0x80000000, remainder 0). A zero divisor is swapped
  // for 1 so the divider never sees it; that result is never committed.
  always_comb begin
    signed_op = is_signed_op(op);
    a_ext     = signed_op ? {{32{a[31]}}, a} : {32'h0, a};
    b_ext     = signed_op ? {{32{b[31]}}, b} : {32'h0, b};
    b_div     = (b == 32'h0) ? 64'd1 : b_ext;
    prod      = a_ext * b_ext;
    quo       = 32'($signed(a_ext) / $signed(b_div));
    rem       = 32'($signed(a_ext) % $signed(b_div));
    if (is_div_op(op)) begin
      result.hi = rem;
      result.lo = quo;
    end else begin
      result.hi = prod[63:32];
      result.lo = prod[31:0];
    end
  end

  // Control FSM and pending-result registers. The counter is loaded with the
  // full latency on accept and the RUN state ends when it reaches 1, which
  // gives exactly LAT busy cycles. pend_wr remembers whether the parked
  // result may be committed; a divide by zero runs its full busy period but
  // leaves HI/LO untouched.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= S_IDLE;
      cnt     <= '0;
      hi_pend <= '0;
      lo_pend <= '0;
      pend_wr <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (accept) begin
            state   <= S_RUN;
            cnt     <= is_div_op(op) ? CNT_W'(DIV_LAT) : CNT_W'(MUL_LAT);
            hi_pend <= result.hi;
            lo_pend <= result.lo;
            pend_wr <= !(is_div_op(op) && (b == 32'h0));
          end
        end
        S_RUN: begin
          if (last_cycle) begin
            state   <= S_IDLE;
            cnt     <= '0;
            pend_wr <= 1'b0;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        default: begin
          state <= S_IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

  // HI/LO architectural registers. They only change on a commit or on an
  // MTHI/MTLO while idle, so they hold the pre-operation values for the
  // whole busy period.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hi <= '0;
      lo <= '0;
    end else if (commit) begin
      hi <= hi_pend;
      lo <= lo_pend;
    end else if (mt_ok && (op == MDU_MTHI)) begin
      hi <= a;
    end else if (mt_ok && (op == MDU_MTLO)) begin
      lo <= a;
    end
  end

  // busy is a pure decode of the state flop, so it has no path from inputs.
  assign busy = (state == S_RUN);

  // The stall unit must hold off any new multiply/divide-class instruction
  // while an operation is in flight; such a request is dropped here.
  a_no_req_in_run: assert property (
    @(posedge clk) disable iff (!reset)
    ((state == S_RUN) && !flush) |-> !(start || (op == MDU_MTHI) || (op == MDU_MTLO))
  );

endmodule

// File: tb/tb_mdu.sv
// -----------------------------------------------------------------------------
// tb_mdu
//
// Self-checking bench for mdu. A table of directed vectors with hand-computed
// HI/LO and busy lengths is run back to back, followed by hand-written
// sequences for flush, flush during RUN and reset during RUN.
// -----------------------------------------------------------------------------
module tb_mdu;
  import mdu_pkg::*;

  logic        clk   = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [2:0]  op    = MDU_NONE;
  logic [31:0] a     = '0;
  logic [31:0] b     = '0;
  logic        flush = 1'b0;
  logic        busy;
  logic [31:0] hi;
  logic [31:0] lo;

  int num_checks = 0;
  int num_errors = 0;

  logic [31:0] model_hi = '0;
  logic [31:0] model_lo = '0;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp_hi;
    logic [31:0] exp_lo;
    int          exp_lat;
  } vec_t;

  localparam int NV = 15;
  vec_t vecs [NV];

  mdu #(
    .MUL_LAT(5),
    .DIV_LAT(10)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .start(start),
    .op   (op),
    .a    (a),
    .b    (b),
    .flush(flush),
    .busy (busy),
    .hi   (hi),
    .lo   (lo)
  );

  always #5 clk = ~clk;

  // Watchdog in case something blocks outside the bounded loops.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not complete in time");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    num_checks++;
    if (actual !== expected) begin
      num_errors++;
      $display("[TB] FAIL %s: actual=%h required=%h", name, actual, expected);
    end
  endtask

  // Called at a negedge (cycle T). Drives one instruction for a single cycle,
  // then counts busy cycles, checking that HI/LO hold the model values while
  // busy. flush_cycle = k raises flush across the edge ending cycle T+k.
  // Returns at the negedge of the first cycle with busy low.
  task automatic applyStimulus(input logic [2:0] op_i, input logic [31:0] a_i,
                               input logic [31:0] b_i, input logic flush_i,
                               input int flush_cycle, output int lat);
    op    = op_i;
    a     = a_i;
    b     = b_i;
    start = is_muldiv(op_i);
    flush = flush_i;
    lat   = 0;
    @(negedge clk);
    start = 1'b0;
    op    = MDU_NONE;
    flush = 1'b0;
    while ((busy === 1'b1) && (lat < 40)) begin
      lat++;
      checkOutput("hi held during run", hi, model_hi);
      checkOutput("lo held during run", lo, model_lo);
      flush = (lat == flush_cycle);
      @(negedge clk);
    end
    flush = 1'b0;
  endtask

  initial begin
    int lat;

    vecs[0]  = '{MDU_MULT,  32'hFFFFFFFE, 32'h00000003, 32'hFFFFFFFF, 32'hFFFFFFFA, 5};
    vecs[1]  = '{MDU_MULTU, 32'hFFFFFFFE, 32'h00000003, 32'h00000002, 32'hFFFFFFFA, 5};
    vecs[2]  = '{MDU_DIV,   32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD, 10};
    vecs[3]  = '{MDU_DIVU,  32'h00000007, 32'h00000002, 32'h00000001, 32'h00000003, 10};
    vecs[4]  = '{MDU_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 10};
    vecs[5]  = '{MDU_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 5};
    vecs[6]  = '{MDU_MULT,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 32'h00000001, 5};
    vecs[7]  = '{MDU_DIVU,  32'hFFFFFFFF, 32'h00000010, 32'h0000000F, 32'h0FFFFFFF, 10};
    vecs[8]  = '{MDU_DIV,   32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 10};
    vecs[9]  = '{MDU_MTHI,  32'h12345678, 32'h00000000, 32'h12345678, 32'hFFFFFFFD, 0};
    vecs[10] = '{MDU_DIV,   32'h00000005, 32'h00000000, 32'h12345678, 32'hFFFFFFFD, 10};
    vecs[11] = '{MDU_MTLO,  32'hCAFEBABE, 32'h00000000, 32'h12345678, 32'hCAFEBABE, 0};
    vecs[12] = '{MDU_DIVU,  32'h00000009, 32'h00000000, 32'h12345678, 32'hCAFEBABE, 10};
    vecs[13] = '{MDU_MULT,  32'h7FFFFFFF, 32'h80000000, 32'hC0000000, 32'h80000000, 5};
    vecs[14] = '{MDU_DIV,   32'h80000000, 32'h00000003, 32'hFFFFFFFE, 32'hD5555556, 10};

    // Reset state while reset is held low.
    #2 reset = 1'b0;
    repeat (2) @(negedge clk);
    checkOutput("reset busy", {31'h0, busy}, 32'h0);
    checkOutput("reset hi", hi, 32'h0);
    checkOutput("reset lo", lo, 32'h0);
    reset = 1'b1;
    @(negedge clk);

    // Directed vectors, issued back to back.
    for (int i = 0; i < NV; i++) begin
      applyStimulus(vecs[i].op, vecs[i].a, vecs[i].b, 1'b0, -1, lat);
      checkOutput($sformatf("vec%0d busy cycles", i), 32'(lat), 32'(vecs[i].exp_lat));
      checkOutput($sformatf("vec%0d hi", i), hi, vecs[i].exp_hi);
      checkOutput($sformatf("vec%0d lo", i), lo, vecs[i].exp_lo);
      model_hi = vecs[i].exp_hi;
      model_lo = vecs[i].exp_lo;
    end

    // MULT squashed by flush in its start cycle.
    applyStimulus(MDU_MULT, 32'h00000002, 32'h00000003, 1'b1, -1, lat);
    checkOutput("flushed mult busy cycles", 32'(lat), 32'd0);
    @(negedge clk);
    checkOutput("flushed mult busy after", {31'h0, busy}, 32'h0);
    checkOutput("flushed mult hi", hi, model_hi);
    checkOutput("flushed mult lo", lo, model_lo);

    // MTLO / MTHI squashed by flush.
    applyStimulus(MDU_MTLO, 32'hDEADBEEF, 32'h0, 1'b1, -1, lat);
    checkOutput("flushed mtlo lo", lo, model_lo);
    applyStimulus(MDU_MTHI, 32'hDEADBEEF, 32'h0, 1'b1, -1, lat);
    checkOutput("flushed mthi hi", hi, model_hi);

    // Flush during RUN does not abort the operation.
    applyStimulus(MDU_MULT, 32'h00010000, 32'h00010000, 1'b0, 2, lat);
    checkOutput("flush in run busy cycles", 32'(lat), 32'd5);
    checkOutput("flush in run hi", hi, 32'h00000001);
    checkOutput("flush in run lo", lo, 32'h00000000);
    model_hi = 32'h00000001;
    model_lo = 32'h00000000;

    // Reset asserted in cycle T+4 of a DIV: outputs clear immediately.
    op    = MDU_DIV;
    a     = 32'd100;
    b     = 32'd7;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    op    = MDU_NONE;
    checkOutput("div before reset busy", {31'h0, busy}, 32'h1);
    repeat (3) @(negedge clk);
    reset = 1'b0;
    #1;
    checkOutput("reset in run busy", {31'h0, busy}, 32'h0);
    checkOutput("reset in run hi", hi, 32'h0);
    checkOutput("reset in run lo", lo, 32'h0);
    @(negedge clk);
    reset = 1'b1;
    model_hi = 32'h0;
    model_lo = 32'h0;
    @(negedge clk);

    // Unit works normally after reset; the discarded DIV never commits.
    applyStimulus(MDU_MULTU, 32'd5, 32'd5, 1'b0, -1, lat);
    checkOutput("post reset multu busy cycles", 32'(lat), 32'd5);
    checkOutput("post reset multu hi", hi, 32'h0);
    checkOutput("post reset multu lo", lo, 32'd25);
    repeat (8) @(negedge clk);
    checkOutput("post reset idle hi", hi, 32'h0);
    checkOutput("post reset idle lo", lo, 32'd25);

    $display("Simulation finished: %0d checks, %0d errors", num_checks, num_errors);
    $finish;
  end

endmodule
